// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the dual-port RAM arbiter.
package ram_arb_pkg;

    typedef enum logic {INIT, RUN} state_t;

    localparam int unsigned AW_DEFAULT = 5;
    localparam int unsigned DEPTH      = 2**AW_DEFAULT;
    localparam int unsigned MAXREQ     = 8;

    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;

    // First set bit of req_mask, scanning upward from ptr, modulo n.
    function automatic pick_t rr_pick(input logic [MAXREQ-1:0] req_mask,
                                      input logic [2:0]        ptr,
                                      input int unsigned       n);
        pick_t       r;
        int unsigned j;
        r = '0;
        for (int unsigned k = 0; k < MAXREQ; k++) begin
            j = ({29'd0, ptr} + k) % n;
            if (k < n && !r.found && req_mask[j[2:0]]) begin
                r.found = 1'b1;
                r.idx   = j[2:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ram_dp_arbiter_rr_picker.sv
// Combinational round-robin scan of a request mask starting at a pointer.
module rr_picker
    import ram_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = 2
) (
    input  logic [NREQ-1:0] mask,
    input  logic [PW-1:0]   ptr,
    output logic            found,
    output logic [PW-1:0]   idx
);

    pick_t p;

    // Widen to the helper's fixed width, then narrow the result back.
    always_comb begin
        p     = rr_pick(MAXREQ'(mask), 3'(ptr), NREQ);
        found = p.found;
        idx   = PW'(p.idx);
    end

endmodule

// File: rtl/ram_dp_arbiter.sv
// Shares one dual-port RAM among NREQ requesters: init sweep, then
// round-robin dual-issue arbitration with 1-cycle read response routing.
module ram_dp_arbiter
    import ram_arb_pkg::*;
#(
    parameter int unsigned   NREQ     = 4,
    parameter int unsigned   AW       = $clog2(DEPTH),
    parameter int unsigned   DW       = 8,
    parameter logic [DW-1:0] INIT_VAL = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [NREQ*DW-1:0] rdata,
    output logic              init_done,
    output logic              en_a,
    output logic              en_b,
    output logic [AW-1:0]     addr_a,
    output logic [AW-1:0]     addr_b,
    output logic [DW-1:0]     data_in_a,
    output logic [DW-1:0]     data_in_b,
    input  logic [DW-1:0]     data_out_a,
    input  logic [DW-1:0]     data_out_b
);

    localparam int unsigned PW = $clog2(NREQ);

    state_t          state;
    logic [AW-2:0]   init_cnt;
    logic [PW-1:0]   rr_ptr;
    logic            rsp_v_a, rsp_v_b;
    logic [PW-1:0]   rsp_id_a, rsp_id_b;

    logic            w0_found, w1_found;
    logic [PW-1:0]   w0_idx, w1_idx;
    logic [PW-1:0]   ptr1, ptr_after_w1;
    logic [NREQ-1:0] mask1;
    logic [AW-1:0]   addr_w0;
    logic            we_w0;

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick0 (
        .mask  (req),
        .ptr   (rr_ptr),
        .found (w0_found),
        .idx   (w0_idx)
    );

    rr_picker #(.NREQ(NREQ), .PW(PW)) u_pick1 (
        .mask  (mask1),
        .ptr   (ptr1),
        .found (w1_found),
        .idx   (w1_idx)
    );

    // Second-winner mask: drop winner 0 and anything conflicting with it.
    always_comb begin
        addr_w0      = addr[w0_idx*AW +: AW];
        we_w0        = we[w0_idx];
        ptr1         = (w0_idx == PW'(NREQ-1)) ? '0 : w0_idx + 1'b1;
        ptr_after_w1 = (w1_idx == PW'(NREQ-1)) ? '0 : w1_idx + 1'b1;
        mask1        = req;
        mask1[w0_idx] = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (addr[i*AW +: AW] == addr_w0 && (we[i] || we_w0))
                mask1[i] = 1'b0;
        end
    end

    // RAM port drive and grants: sweep pattern in INIT, winners in RUN.
    always_comb begin
        gnt       = '0;
        en_a      = 1'b0;
        en_b      = 1'b0;
        addr_a    = '0;
        addr_b    = '0;
        data_in_a = '0;
        data_in_b = '0;
        if (state == INIT) begin
            en_a      = 1'b1;
            en_b      = 1'b1;
            addr_a    = {init_cnt, 1'b0};
            addr_b    = {init_cnt, 1'b1};
            data_in_a = INIT_VAL;
            data_in_b = INIT_VAL;
        end else begin
            if (w0_found) begin
                gnt[w0_idx] = 1'b1;
                en_a        = we[w0_idx];
                addr_a      = addr_w0;
                data_in_a   = wdata[w0_idx*DW +: DW];
            end
            if (w1_found) begin
                gnt[w1_idx] = 1'b1;
                en_b        = we[w1_idx];
                addr_b      = addr[w1_idx*AW +: AW];
                data_in_b   = wdata[w1_idx*DW +: DW];
            end
        end
    end

    // Route registered RAM read data to the requester that issued the read.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (rsp_v_a) begin
            rvalid[rsp_id_a]           = 1'b1;
            rdata[rsp_id_a*DW +: DW]   = data_out_a;
        end
        if (rsp_v_b) begin
            rvalid[rsp_id_b]           = 1'b1;
            rdata[rsp_id_b*DW +: DW]   = data_out_b;
        end
    end

    // Sweep counter, FSM, round-robin pointer and read-response tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            init_cnt  <= '0;
            rr_ptr    <= '0;
            rsp_v_a   <= 1'b0;
            rsp_v_b   <= 1'b0;
            rsp_id_a  <= '0;
            rsp_id_b  <= '0;
            init_done <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    rsp_v_a  <= 1'b0;
                    rsp_v_b  <= 1'b0;
                    if (init_cnt == '1) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                    end
                end
                RUN: begin
                    rsp_v_a <= w0_found && !we[w0_idx];
                    rsp_v_b <= w1_found && !we[w1_idx];
                    if (w0_found && !we[w0_idx])
                        rsp_id_a <= w0_idx;
                    if (w1_found && !we[w1_idx])
                        rsp_id_b <= w1_idx;
                    // Winner 1 is always scanned after winner 0, so it is the last grant.
                    if (w1_found)
                        rr_ptr <= ptr_after_w1;
                    else if (w0_found)
                        rr_ptr <= ptr1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Scoreboard bench for ram_dp_arbiter with a behavioural RAM and arbiter model.
module tb_ram_dp_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 8;
    localparam int NW   = 2**AW;
    localparam logic [DW-1:0] INIT_V = 8'h00;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req, we, gnt, rvalid;
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata, rdata;
    logic              init_done, en_a, en_b;
    logic [AW-1:0]     addr_a, addr_b;
    logic [DW-1:0]     data_in_a, data_in_b, data_out_a, data_out_b;

    ram_dp_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .INIT_VAL(INIT_V)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .init_done(init_done),
        .en_a(en_a), .en_b(en_b), .addr_a(addr_a), .addr_b(addr_b),
        .data_in_a(data_in_a), .data_in_b(data_in_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with registered, write-through outputs.
    logic [DW-1:0] ram [NW];
    always @(posedge clk) begin
        if (en_a) ram[addr_a] <= data_in_a;
        if (en_b) ram[addr_b] <= data_in_b;
        data_out_a <= en_a ? data_in_a : ram[addr_a];
        data_out_b <= en_b ? data_in_b : ram[addr_b];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct { logic [DW-1:0] data; int due; } exp_t;
    exp_t exp_q[NREQ][$];

    bit            p_req[NREQ];
    bit            p_we[NREQ];
    logic [AW-1:0] p_addr[NREQ];
    logic [DW-1:0] p_wdata[NREQ];

    logic [DW-1:0] mem_m[NW];
    bit            run_m;
    int            init_k;
    int            rr_m;
    logic [NREQ-1:0] last_gnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
        end
    endtask

    task automatic issue(input int i, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req[i]   = 1'b1;
        p_we[i]    = w;
        p_addr[i]  = a;
        p_wdata[i] = d;
    endtask

    function automatic bit any_pending();
        bit r = 1'b0;
        for (int i = 0; i < NREQ; i++) r |= p_req[i];
        return r;
    endfunction

    // Monitor: pops the expected response whenever a requester sees rvalid.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rvalid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_rvalid req%0d @cyc %0d: got 1 want 0", i, cyc);
                    end else begin
                        e = exp_q[i].pop_front();
                        check($sformatf("rdata%0d", i), 32'(rdata[i*DW +: DW]), 32'(e.data));
                        check($sformatf("rlat%0d", i), 32'(cyc), 32'(e.due));
                    end
                end else if (exp_q[i].size() > 0 && exp_q[i][0].due <= cyc) begin
                    total++; bad++;
                    $display("FAIL missing_rvalid req%0d @cyc %0d: got 0 want 1", i, cyc);
                    void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // One clock of stimulus; the model predicts grants, port drive and read data.
    task automatic tick();
        int w0, w1, last, j;
        logic [NREQ-1:0] eg;
        logic [DW+AW:0]  ea, eb;
        for (int i = 0; i < NREQ; i++) begin
            req[i]               = p_req[i];
            we[i]                = p_we[i];
            addr[i*AW +: AW]     = p_addr[i];
            wdata[i*DW +: DW]    = p_wdata[i];
        end
        #1;
        last_gnt = gnt;
        if (!run_m) begin
            check("init_gnt", 32'(gnt), 32'(0));
            check("init_done_lo", 32'(init_done), 32'(0));
            check("sweep_a", 32'({en_a, addr_a, data_in_a}), 32'({1'b1, AW'(2*init_k), INIT_V}));
            check("sweep_b", 32'({en_b, addr_b, data_in_b}), 32'({1'b1, AW'(2*init_k+1), INIT_V}));
            mem_m[2*init_k]   = INIT_V;
            mem_m[2*init_k+1] = INIT_V;
            init_k++;
            if (init_k == NW/2) run_m = 1'b1;
        end else begin
            check("init_done_hi", 32'(init_done), 32'(1));
            w0 = -1; w1 = -1;
            for (int k = 0; k < NREQ; k++) begin
                j = (rr_m + k) % NREQ;
                if (w0 < 0 && p_req[j]) w0 = j;
            end
            if (w0 >= 0) begin
                for (int k = 1; k < NREQ; k++) begin
                    j = (w0 + k) % NREQ;
                    if (w1 < 0 && p_req[j] &&
                        !(p_addr[j] == p_addr[w0] && (p_we[j] || p_we[w0])))
                        w1 = j;
                end
            end
            eg = '0; ea = '0; eb = '0;
            if (w0 >= 0) begin eg[w0] = 1'b1; ea = {p_we[w0], p_addr[w0], p_wdata[w0]}; end
            if (w1 >= 0) begin eg[w1] = 1'b1; eb = {p_we[w1], p_addr[w1], p_wdata[w1]}; end
            check("gnt", 32'(gnt), 32'(eg));
            check("port_a", 32'({en_a, addr_a, data_in_a}), 32'(ea));
            check("port_b", 32'({en_b, addr_b, data_in_b}), 32'(eb));
            for (int k = 0; k < 2; k++) begin
                j = (k == 0) ? w0 : w1;
                if (j >= 0 && !p_we[j]) exp_q[j].push_back('{mem_m[p_addr[j]], cyc + 1});
            end
            for (int k = 0; k < 2; k++) begin
                j = (k == 0) ? w0 : w1;
                if (j >= 0) begin
                    if (p_we[j]) mem_m[p_addr[j]] = p_wdata[j];
                    p_req[j] = 1'b0;
                end
            end
            last = (w1 >= 0) ? w1 : w0;
            if (last >= 0) rr_m = (last + 1) % NREQ;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        while (any_pending() && n < max_cycles) begin
            tick();
            n++;
        end
        if (any_pending()) begin
            total++; bad++;
            $display("FAIL grant_timeout @cyc %0d: got pending want idle", cyc);
            for (int i = 0; i < NREQ; i++) p_req[i] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_req[i] = 1'b0;
            exp_q[i].delete();
        end
        run_m = 1'b0; init_k = 0; rr_m = 0;
        #1;
        check("rst_rvalid", 32'(rvalid), 32'(0));
        check("rst_init_done", 32'(init_done), 32'(0));
        check("rst_gnt", 32'(gnt), 32'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic sweep_and_read_all();
        issue(0, 1'b0, '0, '0);
        run_until_idle(NW/2 + 4);
        for (int a = 1; a < NW; a++) begin
            issue(0, 1'b0, AW'(a), '0);
            run_until_idle(4);
        end
        tick();
    endtask

    initial begin
        int waitc[NREQ];
        req = '0; we = '0; addr = '0; wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            p_we[i] = 1'b0; p_addr[i] = '0; p_wdata[i] = '0;
        end
        do_reset();

        // Sweep, then read back every word through requester 0.
        sweep_and_read_all();

        // Write then read on the following cycle.
        issue(0, 1'b1, AW'(5), 8'hA5);
        tick();
        issue(1, 1'b0, AW'(5), '0);
        tick();
        tick();

        // Read/read to the same address on both ports.
        issue(0, 1'b0, AW'(3), '0);
        issue(2, 1'b0, AW'(3), '0);
        tick();
        tick();

        // Write/write conflict from pointer 0; requester 3 alone parks the pointer at 0.
        issue(3, 1'b0, AW'(0), '0);
        tick();
        issue(1, 1'b1, AW'(7), 8'h11);
        issue(3, 1'b1, AW'(7), 8'h22);
        run_until_idle(4);
        issue(0, 1'b0, AW'(7), '0);
        tick();
        tick();

        // Fairness with all four holding reads on distinct addresses.
        issue(3, 1'b0, AW'(0), '0);
        tick();
        for (int i = 0; i < NREQ; i++) waitc[i] = 0;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_req[i]) issue(i, 1'b0, AW'(8 + i), '0);
            tick();
            for (int i = 0; i < NREQ; i++) begin
                waitc[i] = last_gnt[i] ? 0 : waitc[i] + 1;
                check($sformatf("fair_wait%0d", i), 32'(waitc[i] > 1), 32'(0));
            end
        end
        run_until_idle(4);
        tick();

        // Random traffic on a narrow address window to provoke conflicts.
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_req[i] && $urandom_range(0, 1) == 1)
                    issue(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
            tick();
        end
        run_until_idle(20);
        tick();

        // Reset the cycle after a read grant, then check the re-sweep.
        issue(0, 1'b0, AW'(5), '0);
        tick();
        do_reset();
        sweep_and_read_all();

        repeat (3) tick();
        for (int i = 0; i < NREQ; i++)
            check($sformatf("drained%0d", i), 32'(exp_q[i].size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ram_dp_arbiter.md
Name: ram_dp_arbiter

Overview:
- Controller and arbiter that shares one 32x8 dual-port RAM among NREQ requesters.
- After reset it sweeps the whole RAM to INIT_VAL using both ports, then serves requests.
- Each cycle it grants up to two requesters round-robin, the first winner on port A and the second on port B, and routes read data back one cycle later.
- Sits between client logic and the RAM; it drives the RAM's enable, address and write-data pins directly.

Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 5, address width (RAM depth 2**AW)
- DW, 8, data width
- INIT_VAL, 8'h00, value written to every word during the init sweep

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  request per requester, held until granted
- we  in  NREQ  1 = write, 0 = read
- addr  in  NREQ*AW  packed request addresses
- wdata  in  NREQ*DW  packed write data
- gnt  out  NREQ  one-hot-per-port grant; request is accepted this cycle
- rvalid  out  NREQ  read data valid for that requester
- rdata  out  NREQ*DW  packed read data
- init_done  out  1  high once the init sweep has completed
- en_a, en_b  out  1  RAM write enables (0 = read)
- addr_a, addr_b  out  AW  RAM addresses
- data_in_a, data_in_b  out  DW  RAM write data
- data_out_a, data_out_b  in  DW  RAM registered read data (valid the cycle after the address)

Behaviour:
- Reset values (async): state=INIT, init_cnt=0, rr_ptr=0, rsp_v_a/b=0, rsp_id_a/b=0, init_done=0. Outputs gnt=0, rvalid=0, rdata=0, en_a/en_b=0.
- FSM: INIT -> RUN when init_cnt reaches 2**AW/2-1 and the write is issued. RUN is held until reset.
- INIT state:
  - en_a=en_b=1, addr_a={init_cnt,0}, addr_b={init_cnt,1}, data_in=INIT_VAL.
  - init_cnt increments each cycle, so the sweep takes 16 cycles at default AW.
  - gnt=0 throughout; requests are ignored and not lost, because requesters hold req.
  - init_done rises on the cycle after the last sweep write.
- RUN state arbitration (combinational on req/we/addr):
  - Winner 0 = first i with req[i]=1, scanning from rr_ptr upward mod NREQ.
  - Winner 1 = next such i after winner 0 that has no conflict with winner 0.
  - Conflict = same address AND (we of either = 1).
  - Conflicting requesters are skipped this cycle, not blocked forever.
  - Read/read to the same address is allowed on both ports.
- Port drive:
  - Winner 0 drives port A with en_a=we, addr_a, data_in_a.
  - Winner 1 drives port B the same way.
  - An unused port gets en=0, addr=0, data_in=0, which is a harmless read.
- gnt[i]=1 in the same cycle for each winner; the request is consumed at that clock edge.
- rr_ptr update: set to (last granted index + 1) mod NREQ. If there is no grant, rr_ptr is unchanged.
- Read response pipeline:
  - On a granted read, rsp_v_x<=1 and rsp_id_x<=winner index; otherwise rsp_v_x<=0.
  - Next cycle, rvalid[rsp_id_a]=rsp_v_a with rdata slice = data_out_a; same for port B.
  - Read latency is exactly 1 cycle after gnt.
  - Writes produce no rvalid; the RAM's write-through data_out is ignored.
- Ordering: a write granted in cycle t is visible to a read granted in cycle t+1 or later.
- Reset mid-operation: pending responses are dropped (rvalid=0) and the FSM re-enters INIT, so the RAM is re-swept.
- Width rules: index arithmetic is modulo NREQ, with $clog2(NREQ) bits for the pointer.

Decomposition:
- Package ram_arb_pkg holds:
  - typedef state_t {INIT, RUN}
  - localparam DEPTH = 2**AW
  - function rr_pick(req_mask, ptr) returning {found, idx}
- One natural sub-module: rr_picker. It is a combinational priority scan from a pointer with a mask input, instantiated twice. The second instance is masked by the winner-0 bit and by conflicting requesters.

Test Plan:
- Init sweep: release rst, then read all 32 addresses via requester 0. Require init_done after 16 cycles and every rdata=8'h00.
- Write then read: cycle t, req0 writes addr 5 = 8'hA5. Cycle t+1, req1 reads addr 5. Require gnt both cycles, rvalid[1] at t+2, rdata1=8'hA5.
- Dual issue: req0 reads addr 3 and req2 reads addr 3 together. Require both granted (A and B) and both rvalid the next cycle with the same data.
- Write conflict: req1 and req3 both write addr 7 (8'h11, 8'h22) from rr_ptr=0. Require only req1 granted in the first cycle and req3 in the next. A final read of addr 7 returns 8'h22.
- Round-robin fairness: all 4 requesters hold reads on distinct addresses. Require grant pairs {0,1},{2,3},{0,1}… and no requester waits more than 1 cycle.
- Reset mid-flight: assert rst in the cycle after a read grant. Require rvalid=0, init_done=0, and the sweep restarting from address 0.
